// File: rtl/sar_search_pkg.sv
// rtl/sar_search_pkg.sv - shared state type, width and midpoint helper for sar_search_ctrl
package sar_search_pkg;

  localparam int SAR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } sar_state_t;

  // Widened by one bit so the span and sum can never wrap, even for lo=0, hi=all-ones.
  function automatic logic [SAR_WIDTH-1:0] sar_mid(
    input logic [SAR_WIDTH-1:0] lo,
    input logic [SAR_WIDTH-1:0] hi
  );
    logic [SAR_WIDTH:0] w_span;
    logic [SAR_WIDTH:0] w_sum;
    w_span = {1'b0, hi} - {1'b0, lo};
    w_sum  = {1'b0, lo} + (w_span >> 1);
    return SAR_WIDTH'(w_sum);
  endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - binary-search initiator driving trial values to an external comparator
module sar_search_ctrl
  import sar_search_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] trial,
  output logic             trial_valid,
  input  logic             cmp_valid,
  input  logic             cmp_equal,
  input  logic             cmp_greater,
  input  logic             cmp_less,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result
);

  sar_state_t       r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_trial;
  logic             r_found;
  logic             r_error;
  logic [WIDTH-1:0] r_result;

  sar_state_t       w_state_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_trial_nxt;
  logic             w_found_nxt;
  logic             w_error_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic             w_onehot;

  assign w_onehot = $onehot({cmp_equal, cmp_greater, cmp_less});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_lo     <= '0;
      r_hi     <= '1;
      r_trial  <= '0;
      r_found  <= 1'b0;
      r_error  <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_lo     <= w_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_trial  <= w_trial_nxt;
      r_found  <= w_found_nxt;
      r_error  <= w_error_nxt;
      r_result <= w_result_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_trial_nxt  = r_trial;
    w_found_nxt  = r_found;
    w_error_nxt  = r_error;
    w_result_nxt = r_result;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_lo_nxt     = '0;
          w_hi_nxt     = '1;
          w_trial_nxt  = sar_mid('0, '1);
          w_found_nxt  = 1'b0;
          w_error_nxt  = 1'b0;
          w_result_nxt = '0;
          w_state_nxt  = PROBE;
        end
      end
      PROBE: begin
        if (cmp_valid) begin
          if (!w_onehot) begin
            w_error_nxt = 1'b1;
            w_found_nxt = 1'b0;
            w_state_nxt = DONE;
          end else if (cmp_equal) begin
            w_result_nxt = r_trial;
            w_found_nxt  = 1'b1;
            w_state_nxt  = DONE;
          end else if (cmp_greater) begin
            // Trial already at the top bound: nothing left above it.
            if (r_trial == r_hi) begin
              w_state_nxt = DONE;
            end else begin
              w_lo_nxt    = r_trial + WIDTH'(1);
              w_state_nxt = STEP;
            end
          end else begin
            if (r_trial == r_lo) begin
              w_state_nxt = DONE;
            end else begin
              w_hi_nxt    = r_trial - WIDTH'(1);
              w_state_nxt = STEP;
            end
          end
        end
      end
      STEP: begin
        w_trial_nxt = sar_mid(r_lo, r_hi);
        w_state_nxt = PROBE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (abort) begin
      w_state_nxt  = IDLE;
      w_trial_nxt  = '0;
      w_found_nxt  = 1'b0;
      w_error_nxt  = 1'b0;
      w_result_nxt = '0;
    end
  end

  always_comb begin
    trial_valid = (r_state == PROBE);
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
  end

  assign trial  = r_trial;
  assign found  = r_found;
  assign error  = r_error;
  assign result = r_result;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb/tb_sar_search_ctrl.sv - scoreboard bench for sar_search_ctrl with a modelled comparator
module tb_sar_search_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cmp_valid = 1'b0;
  logic       cmp_equal = 1'b0;
  logic       cmp_greater = 1'b0;
  logic       cmp_less = 1'b0;
  logic [7:0] trial;
  logic [7:0] result;
  logic       trial_valid;
  logic       busy;
  logic       done;
  logic       found;
  logic       error;

  always #5 clk = ~clk;

  sar_search_ctrl #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .trial       (trial),
    .trial_valid (trial_valid),
    .cmp_valid   (cmp_valid),
    .cmp_equal   (cmp_equal),
    .cmp_greater (cmp_greater),
    .cmp_less    (cmp_less),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .error       (error),
    .result      (result)
  );

  typedef struct {
    logic       found;
    logic       error;
    logic [7:0] result;
    int         probes;
  } exp_t;

  logic [7:0] q_trial[$];
  exp_t       q_res[$];
  logic [7:0] seq[$];

  int         n_checks = 0;
  int         n_fail = 0;
  int         acc = 0;
  int         done_cnt = 0;
  int         probes = 0;
  logic [7:0] hid_a = 8'h00;
  int         cmp_mode = 0;
  int         cmp_dly = 0;
  logic       busy_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_trials();
    foreach (seq[i]) q_trial.push_back(seq[i]);
  endtask

  task automatic expect_search(input logic f, input logic e, input logic [7:0] r);
    exp_t x;
    push_trials();
    x.found  = f;
    x.error  = e;
    x.result = r;
    x.probes = seq.size();
    q_res.push_back(x);
  endtask

  task automatic run(input logic [7:0] a, input int mode, input int dly, input int hold);
    int base;
    hid_a    = a;
    cmp_mode = mode;
    cmp_dly  = dly;
    base     = done_cnt;
    start    = 1'b1;
    cyc(hold);
    start    = 1'b0;
    for (int k = 0; k < 400 && done_cnt == base; k++) cyc(1);
    chk("done_seen", done_cnt, base + 1);
    cyc(2);
  endtask

  task automatic check_idle_clear(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_trial_valid"}, trial_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_trial"}, trial, 0);
  endtask

  // Ideal comparator against hid_a (mode 0), always-Less liar (1), or illegal Equal+Greater (2).
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!trial_valid) begin
        cnt = 0;
        cmp_valid = 1'b0;
        {cmp_equal, cmp_greater, cmp_less} = 3'b000;
      end else begin
        if (cnt >= cmp_dly) begin
          cmp_valid = 1'b1;
          case (cmp_mode)
            0: begin
              cmp_equal   = (hid_a == trial);
              cmp_greater = (hid_a > trial);
              cmp_less    = (hid_a < trial);
            end
            1: {cmp_equal, cmp_greater, cmp_less} = 3'b001;
            default: {cmp_equal, cmp_greater, cmp_less} = 3'b110;
          endcase
        end else begin
          cmp_valid = 1'b0;
        end
        cnt++;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        probes   = 0;
        busy_chk = 1'b0;
      end else begin
        if (busy_chk) begin
          chk("busy_after_done", busy, 0);
          busy_chk = 1'b0;
        end
        if (trial_valid && (cmp_valid || abort)) begin
          if (q_trial.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_probe actual=%0h required=none", trial);
          end else begin
            chk("probe_trial", trial, q_trial.pop_front());
          end
          acc++;
          probes++;
          if (abort) probes = 0;
        end else if (trial_valid && q_trial.size() != 0) begin
          chk("trial_hold", trial, q_trial[0]);
        end
        if (done) begin
          if (q_res.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done actual=1 required=0");
          end else begin
            e = q_res.pop_front();
            chk("found", found, e.found);
            chk("error", error, e.error);
            chk("result", result, e.result);
            chk("probe_count", probes, e.probes);
            chk("trials_left", 32'(q_trial.size()), 0);
          end
          probes   = 0;
          done_cnt++;
          busy_chk = 1'b1;
        end
      end
    end
  end

  initial begin
    int base;
    cyc(3);
    check_idle_clear("reset");
    rst_n = 1'b1;
    cyc(2);
    chk("post_reset_busy", busy, 0);

    seq = '{8'h7F, 8'hBF, 8'h9F, 8'hAF, 8'hA7, 8'hA3, 8'hA5};
    expect_search(1'b1, 1'b0, 8'hA5);
    run(8'hA5, 0, 0, 1);
    chk("result_held", result, 8'hA5);
    chk("found_held", found, 1);

    seq = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFF};
    expect_search(1'b1, 1'b0, 8'hFF);
    run(8'hFF, 0, 0, 1);

    seq = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    expect_search(1'b1, 1'b0, 8'h00);
    run(8'h00, 0, 0, 1);

    // Slow comparator, with start held high while busy.
    seq = '{8'h7F, 8'h3F, 8'h1F, 8'h2F, 8'h37, 8'h3B, 8'h3D, 8'h3C};
    expect_search(1'b1, 1'b0, 8'h3C);
    run(8'h3C, 0, 3, 5);

    seq = '{8'h7F, 8'hBF, 8'h9F};
    push_trials();
    hid_a    = 8'hA5;
    cmp_mode = 0;
    cmp_dly  = 3;
    base     = acc;
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
    for (int k = 0; k < 400 && !(acc == base + 2 && trial_valid); k++) cyc(1);
    chk("abort_reached_probe3", acc, base + 2);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check_idle_clear("abort");
    chk("abort_trials_left", 32'(q_trial.size()), 0);
    cyc(20);

    seq = '{8'h7F, 8'hBF, 8'h9F, 8'hAF, 8'hA7, 8'hA3, 8'hA5};
    q_trial.delete();
    seq = '{8'h7F};
    expect_search(1'b0, 1'b1, 8'h00);
    run(8'h00, 2, 0, 1);

    seq = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    expect_search(1'b0, 1'b0, 8'h00);
    run(8'h00, 1, 0, 1);

    seq = '{8'h7F, 8'h3F};
    push_trials();
    hid_a    = 8'h3C;
    cmp_mode = 0;
    cmp_dly  = 0;
    base     = acc;
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
    for (int k = 0; k < 400 && acc != base + 2; k++) cyc(1);
    chk("reset_reached_probe2", acc, base + 2);
    rst_n = 1'b0;
    cyc(1);
    check_idle_clear("midreset");
    chk("midreset_trials_left", 32'(q_trial.size()), 0);
    rst_n = 1'b1;
    cyc(10);

    seq = '{8'h7F, 8'hBF, 8'h9F, 8'h8F, 8'h87, 8'h83, 8'h81};
    expect_search(1'b1, 1'b0, 8'h81);
    run(8'h81, 0, 0, 1);

    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
